grid_port_arbiter: RTL and testbench

GRID_PORT_ARBITER -- requirements
Module: grid_port_arbiter

---
 rtl/placement_pkg.sv | 15 +
 rtl/rr_picker.sv | 25 ++
 rtl/grid_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_grid_port_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/placement_pkg.sv
// placement_pkg: FSM state encoding and default bus widths shared by grid_port_arbiter and its bench
package placement_pkg;

    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_RWAIT,
        S_RDATA,
        S_LOCKED
    } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin select, first requester after last in circular order wins
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          valid,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] k;

    // Walk offsets from farthest to nearest so the nearest pending requester is the last one kept
    always_comb begin
        valid = |req;
        idx   = '0;
        k     = '0;
        for (int i = N; i >= 1; i--) begin
            k = IW'((int'(last) + i) % N);
            if (req[k]) idx = k;
        end
    end

endmodule

// File: rtl/grid_port_arbiter.sv
// grid_port_arbiter: round-robin arbiter sharing one RAM-style port among N_REQ requesters; port locking under GRID_ARB_LOCK_EN
module grid_port_arbiter
    import placement_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int AW       = DEF_AW,
    parameter int DW       = DEF_DW,
    parameter int LOCK_MAX = 63
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ-1:0]    we,
    input  logic [N_REQ*AW-1:0] addr,
    input  logic [N_REQ*DW-1:0] wdata,
`ifdef GRID_ARB_LOCK_EN
    input  logic [N_REQ-1:0]    lock,
`endif
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    rvalid,
    output logic [DW-1:0]       rdata,
    output logic                lock_err,
    output logic                busy,
    output logic                mem_read,
    output logic                mem_write,
    output logic [AW-1:0]       mem_addr,
    output logic [DW-1:0]       mem_din,
    input  logic [DW-1:0]       mem_dout
);

    localparam int IW = $clog2(N_REQ);

    // Reject configurations the round-robin indexing and lock counter are not sized for
    if (N_REQ < 2 || N_REQ > 8 || LOCK_MAX < 1) begin : g_bad_cfg
        $error("grid_port_arbiter: unsupported N_REQ or LOCK_MAX");
    end

    arb_state_e         state_q;
    logic [IW-1:0]      owner_q;
    logic               we_q;
    logic [N_REQ-1:0]   gnt_q;
    logic [N_REQ-1:0]   rvalid_q;
    logic [DW-1:0]      rdata_q;
    logic               mem_read_q;
    logic               mem_write_q;
    logic [AW-1:0]      mem_addr_q;
    logic [DW-1:0]      mem_din_q;

    logic               pick_valid;
    logic [IW-1:0]      pick_idx;
    logic [IW-1:0]      sel_idx;
    logic               launch;
    logic               sel_we;
    logic [AW-1:0]      sel_addr;
    logic [DW-1:0]      sel_wdata;

    // owner_q doubles as last_owner: it is rewritten on every grant and seeds the next search
    rr_picker #(
        .N  (N_REQ),
        .IW (IW)
    ) u_picker (
        .req   (req),
        .last  (owner_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

`ifdef GRID_ARB_LOCK_EN
    localparam int CW = $clog2(LOCK_MAX + 1);

    logic [CW-1:0]      cnt_q;
    logic               lock_err_q;
    logic               lock_own;

    assign lock_own = lock[owner_q];
    assign launch   = (state_q == S_IDLE && pick_valid) || (state_q == S_LOCKED && req[owner_q]);
    assign sel_idx  = (state_q == S_LOCKED) ? owner_q : pick_idx;
    assign lock_err = lock_err_q;
`else
    assign launch   = state_q == S_IDLE && pick_valid;
    assign sel_idx  = pick_idx;
    assign lock_err = 1'b0;
`endif

    assign sel_we    = we[sel_idx];
    assign sel_addr  = addr[sel_idx*AW +: AW];
    assign sel_wdata = wdata[sel_idx*DW +: DW];

    assign gnt       = gnt_q;
    assign rvalid    = rvalid_q;
    assign rdata     = rdata_q;
    assign busy      = state_q != S_IDLE;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_din   = mem_din_q;

    // Registered FSM: pulses default low each cycle; a launch latches the request and raises the GRANT outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            owner_q     <= IW'(N_REQ - 1);
            we_q        <= 1'b0;
            gnt_q       <= '0;
            rvalid_q    <= '0;
            rdata_q     <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
`ifdef GRID_ARB_LOCK_EN
            cnt_q       <= '0;
            lock_err_q  <= 1'b0;
`endif
        end else begin
            gnt_q       <= '0;
            rvalid_q    <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
`ifdef GRID_ARB_LOCK_EN
            lock_err_q  <= 1'b0;
`endif
            if (launch) begin
                state_q     <= S_GRANT;
                owner_q     <= sel_idx;
                we_q        <= sel_we;
                gnt_q       <= N_REQ'(1) << sel_idx;
                mem_read_q  <= !sel_we;
                mem_write_q <= sel_we;
                mem_addr_q  <= sel_addr;
                mem_din_q   <= sel_wdata;
`ifdef GRID_ARB_LOCK_EN
                cnt_q       <= '0;
`endif
            end else begin
                case (state_q)
`ifdef GRID_ARB_LOCK_EN
                    S_GRANT: state_q <= !we_q ? S_RWAIT : lock_own ? S_LOCKED : S_IDLE;
                    S_RDATA: state_q <= lock_own ? S_LOCKED : S_IDLE;
                    S_LOCKED: begin
                        if (!lock_own) begin
                            state_q <= S_IDLE;
                            cnt_q   <= '0;
                        end else if (cnt_q == CW'(LOCK_MAX - 1)) begin
                            state_q    <= S_IDLE;
                            cnt_q      <= '0;
                            lock_err_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
`else
                    S_GRANT: state_q <= we_q ? S_IDLE : S_RWAIT;
                    S_RDATA: state_q <= S_IDLE;
`endif
                    S_RWAIT: begin
                        rdata_q  <= mem_dout;
                        rvalid_q <= N_REQ'(1) << owner_q;
                        state_q  <= S_RDATA;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_grid_port_arbiter.sv
// tb_grid_port_arbiter: scoreboard bench with a small RAM model; lock scenarios run when GRID_ARB_LOCK_EN is defined
module tb_grid_port_arbiter;

    localparam int N        = 4;
    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int LOCK_MAX = 63;

    logic            clk;
    logic            reset;
    logic [N-1:0]    req;
    logic [N-1:0]    we;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
`ifdef GRID_ARB_LOCK_EN
    logic [N-1:0]    lock;
`endif
    logic [N-1:0]    gnt;
    logic [N-1:0]    rvalid;
    logic [DW-1:0]   rdata;
    logic            lock_err;
    logic            busy;
    logic            mem_read;
    logic            mem_write;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_din;
    logic [DW-1:0]   mem_dout;

    logic [DW-1:0]   ram [16];
    logic [DW-1:0]   model_mem [16];

    typedef struct {
        int            idx;
        bit            w;
        int            a;
        logic [DW-1:0] d;
        int            t;
    } exp_t;

    exp_t gq[$];
    exp_t rq[$];
    int   rt[$];
    int   lq[$];
    exp_t mg;
    exp_t mr;

    int errors  = 0;
    int checks  = 0;
    int cyc     = 0;
    int m_last  = N - 1;
    int rv_seen = 0;

    grid_port_arbiter #(
        .N_REQ    (N),
        .AW       (AW),
        .DW       (DW),
        .LOCK_MAX (LOCK_MAX)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
`ifdef GRID_ARB_LOCK_EN
        .lock      (lock),
`endif
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .lock_err  (lock_err),
        .busy      (busy),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: write commits at the edge ending the strobe cycle, read data valid the next cycle
    always @(posedge clk) begin
        if (mem_write) ram[mem_addr[3:0]] <= mem_din;
        if (mem_read) mem_dout <= ram[mem_addr[3:0]];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Requesters release req on their grant and then scramble their own fields to prove the access was latched
    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (gnt[k]) begin
                req[k] = 1'b0;
                we[k] = ~we[k];
                addr[k*AW +: AW] = $urandom;
                wdata[k*DW +: DW] = $urandom;
            end
        end
    end

    // Monitor: pop the oldest expectation whenever the DUT presents a grant, read data or lock error
    always @(negedge clk) begin
        if (reset) begin
            if (gnt != '0) begin
                chk("gnt_onehot", 64'($onehot(gnt)), 1);
                if (gq.size() == 0) chk("gnt_unexpected", gnt, 0);
                else begin
                    mg = gq.pop_front();
                    chk("gnt_owner", gnt, 64'(1) << mg.idx);
                    chk("mem_write", mem_write, mg.w);
                    chk("mem_read", mem_read, !mg.w);
                    chk("mem_addr", mem_addr, mg.a);
                    if (mg.w) chk("mem_din", mem_din, mg.d);
                    else rt.push_back(cyc + 2);
                    if (mg.t >= 0) chk("gnt_cycle", cyc, mg.t);
                end
            end else if (mem_read || mem_write) chk("mem_strobe_without_gnt", {mem_read, mem_write}, 0);
            if (rvalid != '0) begin
                rv_seen++;
                if (rq.size() == 0 || rt.size() == 0) chk("rvalid_unexpected", rvalid, 0);
                else begin
                    mr = rq.pop_front();
                    chk("rvalid_owner", rvalid, 64'(1) << mr.idx);
                    chk("rdata", rdata, mr.d);
                    chk("rvalid_cycle", cyc, rt.pop_front());
                end
            end
            if (lock_err) begin
                if (lq.size() == 0) chk("lock_err_unexpected", 1, 0);
                else chk("lock_err_cycle", cyc, lq.pop_front());
            end
        end
    end

    task automatic setup(input int k, input bit w, input int a, input logic [DW-1:0] d);
        we[k] = w;
        addr[k*AW +: AW] = a;
        wdata[k*DW +: DW] = d;
    endtask

    // Reference: accesses are serialised, so memory contents are updated in grant order
    task automatic push_exp(input int k, input int t);
        exp_t e;
        e.idx = k;
        e.w   = we[k];
        e.a   = int'(addr[k*AW +: AW]);
        e.d   = e.w ? wdata[k*DW +: DW] : model_mem[e.a];
        e.t   = t;
        gq.push_back(e);
        if (e.w) model_mem[e.a] = e.d;
        else rq.push_back(e);
        m_last = k;
    endtask

    // All requesters in set raised together: they are served in circular order starting after the last owner
    task automatic launch(input logic [N-1:0] set);
        int start;
        bit first;
        start = m_last;
        first = 1;
        for (int i = 1; i <= N; i++) begin
            if (set[(start + i) % N]) begin
                push_exp((start + i) % N, first ? cyc + 1 : -1);
                first = 0;
            end
        end
        req = set;
    endtask

    task automatic wait_quiet();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (req == '0 && !busy && gq.size() == 0 && rq.size() == 0 && lq.size() == 0) begin
                @(negedge clk);
                return;
            end
        end
        chk("quiet_timeout", 0, 1);
        req = '0;
        gq.delete();
        rq.delete();
        rt.delete();
        lq.delete();
    endtask

    task automatic wait_gnt(input int k);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (gnt[k]) return;
        end
        chk("gnt_timeout", 0, 1);
    endtask

    task automatic wait_rv(input int k);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (rvalid[k]) return;
        end
        chk("rvalid_timeout", 0, 1);
    endtask

    initial begin
        int rv0;
        int g;
        logic [N-1:0] set;
        reset = 0;
        req   = '0;
        we    = '0;
        addr  = '0;
        wdata = '0;
`ifdef GRID_ARB_LOCK_EN
        lock  = '0;
`endif
        for (int i = 0; i < 16; i++) begin
            ram[i] = $urandom;
            model_mem[i] = ram[i];
        end
        ram[5] = 32'hFFFF_FFFF;
        model_mem[5] = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_strobes", {mem_read, mem_write}, 0);
        chk("rst_lock_err", lock_err, 0);
        chk("rst_rdata", rdata, 0);
        reset = 1;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        // All four read at once: grants go 0,1,2,3, then requester 0 alone reads the all-ones word
        for (int k = 0; k < N; k++) setup(k, 0, k + 1, 0);
        launch(4'b1111);
        wait_quiet();
        setup(0, 0, 5, 0);
        launch(4'b0001);
        wait_quiet();

        for (int r = 0; r < 30; r++) begin
            set = N'($urandom_range(1, (1 << N) - 1));
            for (int k = 0; k < N; k++) setup(k, 1'($urandom), $urandom_range(0, 15), $urandom);
            launch(set);
            wait_quiet();
        end

        // Reset while the read is in RWAIT: outputs clear at once and the read never completes
        setup(2, 0, 6, 0);
        launch(4'b0100);
        wait_gnt(2);
        @(negedge clk);
        reset = 0;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_gnt", gnt, 0);
        chk("async_rst_rvalid", rvalid, 0);
        chk("async_rst_strobes", {mem_read, mem_write}, 0);
        chk("async_rst_mem_addr", mem_addr, 0);
        rq.delete();
        rt.delete();
        m_last = N - 1;
        repeat (2) @(negedge clk);
        reset = 1;
        rv0 = rv_seen;
        repeat (6) @(negedge clk);
        chk("no_rvalid_after_reset", rv_seen, rv0);
        setup(0, 0, 1, 0);
        setup(3, 0, 2, 0);
        launch(4'b1001);
        wait_quiet();

`ifdef GRID_ARB_LOCK_EN
        // Locked read then locked write by requester 0 while requester 1 waits for the lock to drop
        lock[0] = 1;
        setup(0, 0, 9, 0);
        launch(4'b0001);
        wait_gnt(0);
        @(negedge clk);
        setup(1, 0, 3, 0);
        req[1] = 1;
        wait_rv(0);
        setup(0, 1, 9, 7);
        push_exp(0, cyc + 2);
        push_exp(1, -1);
        req[0] = 1;
        wait_gnt(0);
        repeat (5) @(negedge clk);
        lock[0] = 0;
        wait_quiet();
        chk("mem9_written", ram[9], 7);

        // Lock held with no traffic: forced release after LOCK_MAX locked cycles, then requester 1 served
        lock[0] = 1;
        setup(0, 1, 2, 32'h55);
        launch(4'b0001);
        wait_gnt(0);
        g = cyc;
        lq.push_back(g + 1 + LOCK_MAX);
        @(negedge clk);
        setup(1, 0, 4, 0);
        push_exp(1, g + 2 + LOCK_MAX);
        req[1] = 1;
        wait_quiet();
        lock[0] = 0;
        repeat (2) @(negedge clk);
`endif

        chk("queues_drained", gq.size() + rq.size() + rt.size() + lq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
